// File: rtl/stopwatch_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | stopwatch_pkg : shared types, button indices and period helper  |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
package stopwatch_pkg;

  typedef enum logic [1:0] {
    STOPPED  = 2'd0,
    RUNNING  = 2'd1,
    CLEARING = 2'd2
  } sw_state_t;

  localparam int SPEED_MAX_DEF = 3;
  localparam int SPEED_W       = $clog2(SPEED_MAX_DEF + 1);

  localparam int NUM_BTN   = 7;
  localparam int IDX_ONOFF = 0;
  localparam int IDX_CLEAR = 1;
  localparam int IDX_REV   = 2;
  localparam int IDX_UP    = 3;
  localparam int IDX_DOWN  = 4;
  localparam int IDX_ADD   = 5;
  localparam int IDX_SUB   = 6;

  // Tick period at a given speed level, never shorter than one cycle.
  function automatic int tick_period(input int div, input int speed);
    int p;
    p = div >> speed;
    return (p < 1) ? 1 : p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stopwatch_ctrl_button_conditioner.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | button_conditioner : synchroniser, debouncer and press detector |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
module button_conditioner #(
  parameter int DB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic RESET,
  input  logic raw,
  output logic level,
  output logic rise_p
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             prev_q;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any sample that agrees with the accepted level restarts the stability count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    rise_d = level_q & ~prev_q;
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level  = level_q;
  assign rise_p = rise_q;

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | stopwatch_ctrl : button front-end and strobe sequencer for the  |
// | 4-digit counter chain                                rev 1.0    |
// +-----------------------------------------------------------------+
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV  = 50_000_000,
  parameter int SPEED_MAX = SPEED_MAX_DEF,
  parameter int DB_CYCLES = 500_000
) (
  input  logic                           clk,
  input  logic                           RESET,
  input  logic                           BTN_ONOFF,
  input  logic                           BTN_CLEAR,
  input  logic                           BTN_REVERSE,
  input  logic                           BTN_SPEED_UP,
  input  logic                           BTN_SPEED_DOWN,
  input  logic                           BTN_ADD,
  input  logic                           BTN_SUBTRACT,
  output logic                           TICK,
  output logic                           RUN,
  output logic                           DIR,
  output logic [$clog2(SPEED_MAX+1)-1:0] SPEED,
  output logic                           CLR,
  output logic                           ADD_P,
  output logic                           SUB_P
);

  localparam int SPW = $clog2(SPEED_MAX + 1);
  localparam int PCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [NUM_BTN-1:0] raw_btn;
  logic [NUM_BTN-1:0] unused_btn_level;
  logic [NUM_BTN-1:0] btn_p;

  assign raw_btn = {BTN_SUBTRACT, BTN_ADD, BTN_SPEED_DOWN, BTN_SPEED_UP,
                    BTN_REVERSE, BTN_CLEAR, BTN_ONOFF};

  generate
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      button_conditioner #(
        .DB_CYCLES(DB_CYCLES)
      ) u_cond (
        .clk   (clk),
        .RESET (RESET),
        .raw   (raw_btn[i]),
        .level (unused_btn_level[i]),
        .rise_p(btn_p[i])
      );
    end
  endgenerate

  logic onoff_p, clear_p, rev_p, up_p, down_p, add_p, sub_p;
  assign onoff_p = btn_p[IDX_ONOFF];
  assign clear_p = btn_p[IDX_CLEAR];
  assign rev_p   = btn_p[IDX_REV];
  assign up_p    = btn_p[IDX_UP];
  assign down_p  = btn_p[IDX_DOWN];
  assign add_p   = btn_p[IDX_ADD];
  assign sub_p   = btn_p[IDX_SUB];

  sw_state_t        state_q, state_d;
  logic             run_q, run_d;
  logic             tick_q, tick_d;
  logic             clr_q, clr_d;
  logic             add_q, add_d;
  logic             sub_q, sub_d;
  logic             dir_q, dir_d;
  logic [SPW-1:0]   speed_q, speed_d;
  logic [PCW-1:0]   pcnt_q, pcnt_d;
  logic             speed_chg;
  int               period;

  always_comb begin
    state_d = state_q;
    if (clear_p) begin
      state_d = CLEARING;
    end else begin
      case (state_q)
        STOPPED:  if (onoff_p) state_d = RUNNING;
        RUNNING:  if (onoff_p) state_d = STOPPED;
        CLEARING: state_d = STOPPED;
        default:  state_d = STOPPED;
      endcase
    end

    speed_d = speed_q;
    if (up_p && !down_p && speed_q != SPW'(SPEED_MAX)) begin
      speed_d = speed_q + 1'b1;
    end else if (down_p && !up_p && speed_q != '0) begin
      speed_d = speed_q - 1'b1;
    end
    speed_chg = (speed_d != speed_q);

    // A speed change restarts the tick phase and suppresses a coincident tick.
    period = tick_period(TICK_DIV, int'(speed_q));
    pcnt_d = '0;
    tick_d = 1'b0;
    if (state_q == RUNNING && state_d == RUNNING && !speed_chg) begin
      if (pcnt_q == PCW'(period - 1)) begin
        tick_d = 1'b1;
      end else begin
        pcnt_d = pcnt_q + 1'b1;
      end
    end

    dir_d = dir_q ^ rev_p;
    add_d = add_p && !sub_p && state_q == STOPPED && state_d == STOPPED;
    sub_d = sub_p && !add_p && state_q == STOPPED && state_d == STOPPED;
    run_d = (state_d == RUNNING);
    clr_d = (state_d == CLEARING);
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q <= STOPPED;
      run_q   <= 1'b0;
      tick_q  <= 1'b0;
      clr_q   <= 1'b0;
      add_q   <= 1'b0;
      sub_q   <= 1'b0;
      dir_q   <= 1'b0;
      speed_q <= '0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      tick_q  <= tick_d;
      clr_q   <= clr_d;
      add_q   <= add_d;
      sub_q   <= sub_d;
      dir_q   <= dir_d;
      speed_q <= speed_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign TICK  = tick_q;
  assign RUN   = run_q;
  assign DIR   = dir_q;
  assign SPEED = speed_q;
  assign CLR   = clr_q;
  assign ADD_P = add_q;
  assign SUB_P = sub_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_stopwatch_ctrl : vectors, corner sequences and random run    |
// | against a window-based reference model               rev 1.0    |
// +-----------------------------------------------------------------+
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  localparam int TICK_DIV  = 16;
  localparam int SPEED_MAX = 3;
  localparam int DB        = 4;

  localparam logic [6:0] B_ONOFF = 7'b0000001;
  localparam logic [6:0] B_CLEAR = 7'b0000010;
  localparam logic [6:0] B_REV   = 7'b0000100;
  localparam logic [6:0] B_UP    = 7'b0001000;
  localparam logic [6:0] B_DOWN  = 7'b0010000;
  localparam logic [6:0] B_ADD   = 7'b0100000;
  localparam logic [6:0] B_SUB   = 7'b1000000;

  logic               clk   = 1'b0;
  logic               RESET = 1'b1;
  logic [6:0]         raw   = '0;
  logic               TICK, RUN, DIR, CLR, ADD_P, SUB_P;
  logic [SPEED_W-1:0] SPEED;

  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .TICK_DIV (TICK_DIV),
    .SPEED_MAX(SPEED_MAX),
    .DB_CYCLES(DB)
  ) dut (
    .clk           (clk),
    .RESET         (RESET),
    .BTN_ONOFF     (raw[0]),
    .BTN_CLEAR     (raw[1]),
    .BTN_REVERSE   (raw[2]),
    .BTN_SPEED_UP  (raw[3]),
    .BTN_SPEED_DOWN(raw[4]),
    .BTN_ADD       (raw[5]),
    .BTN_SUBTRACT  (raw[6]),
    .TICK          (TICK),
    .RUN           (RUN),
    .DIR           (DIR),
    .SPEED         (SPEED),
    .CLR           (CLR),
    .ADD_P         (ADD_P),
    .SUB_P         (SUB_P)
  );

  // Reference model: a button level flips once the last DB synchronised samples
  // all disagree with it; its press acts on the controller two edges later.
  bit [15:0] hist   [7];
  bit        lvl    [7];
  bit [1:0]  rose_h [7];
  bit        p      [7];
  int        m_state;            // 0 stopped, 1 running, 2 clearing
  int        m_speed, m_next, m_nspeed, m_per;
  bit        m_tick, m_run, m_dir, m_clr, m_add, m_sub;
  longint    ecount, phase_start;

  always @(posedge clk or posedge RESET) begin : model
    if (RESET) begin
      for (int i = 0; i < 7; i++) begin
        hist[i] = '0; lvl[i] = 1'b0; rose_h[i] = '0; p[i] = 1'b0;
      end
      m_state = 0; m_speed = 0; m_tick = 0; m_run = 0; m_dir = 0;
      m_clr = 0; m_add = 0; m_sub = 0; phase_start = 0; ecount = 0;
    end else begin
      ecount++;
      for (int i = 0; i < 7; i++) begin : btn
        bit all_diff;
        p[i] = rose_h[i][1];
        all_diff = 1'b1;
        for (int j = 1; j <= DB; j++) if (hist[i][j] == lvl[i]) all_diff = 1'b0;
        rose_h[i] = {rose_h[i][0], all_diff & ~lvl[i]};
        if (all_diff) lvl[i] = ~lvl[i];
        hist[i] = {hist[i][14:0], raw[i]};
      end
      if (p[1])              m_next = 2;
      else if (m_state == 2) m_next = 0;
      else if (p[0])         m_next = (m_state == 0) ? 1 : 0;
      else                   m_next = m_state;
      m_nspeed = m_speed;
      if (p[3] && !p[4] && m_speed < SPEED_MAX) m_nspeed = m_speed + 1;
      else if (p[4] && !p[3] && m_speed > 0)    m_nspeed = m_speed - 1;
      m_per = TICK_DIV >> m_speed;
      if (m_per < 1) m_per = 1;
      m_tick = (m_state == 1) && (m_next == 1) && (m_nspeed == m_speed) &&
               ((ecount - phase_start) % m_per == 0);
      if ((m_state != 1 && m_next == 1) || m_nspeed != m_speed) phase_start = ecount;
      m_dir   = m_dir ^ p[2];
      m_add   = p[5] && !p[6] && m_state == 0 && m_next == 0;
      m_sub   = p[6] && !p[5] && m_state == 0 && m_next == 0;
      m_run   = (m_next == 1);
      m_clr   = (m_next == 2);
      m_state = m_next;
      m_speed = m_nspeed;
    end
  end

  int vectors = 0;
  int errors  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    if (chk_en) begin
      check("model", 32'({TICK, RUN, DIR, SPEED, CLR, ADD_P, SUB_P}),
            32'({m_tick, m_run, m_dir, SPEED_W'(m_speed), m_clr, m_add, m_sub}));
      check("strobe_excl", 32'($onehot0({TICK, CLR, ADD_P, SUB_P})), 32'd1);
    end
  endtask

  task automatic press_count(input logic [6:0] mask, input int hold,
                             output int na, output int ns, output int nc, output int nt);
    na = 0; ns = 0; nc = 0; nt = 0;
    raw = mask;
    for (int n = 0; n < hold + DB + 6; n++) begin
      cyc();
      na += int'(ADD_P); ns += int'(SUB_P); nc += int'(CLR); nt += int'(TICK);
      if (n == hold - 1) raw = '0;
    end
  endtask

  task automatic press(input logic [6:0] mask);
    int a, s, c, t;
    press_count(mask, 8, a, s, c, t);
  endtask

  task automatic tick_gap(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!TICK && n < 64);
  endtask

  typedef struct {
    logic [6:0] btn;
    bit         e_run;
    bit         e_dir;
    int         e_speed;
  } vec_t;

  vec_t tbl[10];
  int   n, na, ns, nc, nt, toggles, first, dir0, t1, t2, dflip;
  bit   r0;
  int   rem[7];

  initial begin
    tbl[0] = '{B_ONOFF,        1, 0, 1 - 1};
    tbl[1] = '{B_UP,           1, 0, 1};
    tbl[2] = '{B_REV,          1, 1, 1};
    tbl[3] = '{B_UP | B_DOWN,  1, 1, 1};
    tbl[4] = '{B_ONOFF,        0, 1, 1};
    tbl[5] = '{B_DOWN,         0, 1, 0};
    tbl[6] = '{B_DOWN,         0, 1, 0};
    tbl[7] = '{B_CLEAR,        0, 1, 0};
    tbl[8] = '{B_ONOFF,        1, 1, 0};
    tbl[9] = '{B_CLEAR|B_ONOFF,0, 1, 0};

    repeat (3) cyc();
    check("reset_outputs", 32'({TICK, RUN, DIR, SPEED, CLR, ADD_P, SUB_P}), 32'd0);
    chk_en = 1'b1;
    RESET  = 1'b0;
    repeat (2) cyc();

    for (int i = 0; i < 10; i++) begin
      press(tbl[i].btn);
      check($sformatf("tbl%0d_run", i),   32'(RUN),   32'(tbl[i].e_run));
      check($sformatf("tbl%0d_dir", i),   32'(DIR),   32'(tbl[i].e_dir));
      check($sformatf("tbl%0d_speed", i), 32'(SPEED), 32'(tbl[i].e_speed));
    end

    // Reset mid-run, then the press-to-RUN latency.
    press(B_ONOFF);
    repeat (5) cyc();
    check("run_before_reset", 32'(RUN), 32'd1);
    RESET = 1'b1;
    #1;
    check("async_reset", 32'({TICK, RUN, DIR, SPEED, CLR, ADD_P, SUB_P}), 32'd0);
    cyc();
    RESET = 1'b0;
    cyc();
    raw = B_ONOFF;
    n = 0;
    while (!RUN && n < 30) begin cyc(); n++; end
    check("onoff_latency", 32'(n), 32'd8);
    raw = '0;

    // Tick period across speed levels.
    tick_gap(n);
    check("first_tick", 32'(n), 32'd16 - 32'(DB + 6) + 32'(DB + 6));
    tick_gap(n);
    check("period_s0", 32'(n), 32'd16);
    repeat (3) press(B_UP);
    check("speed_3", 32'(SPEED), 32'd3);
    tick_gap(n);
    tick_gap(n);
    check("period_s3", 32'(n), 32'd2);
    press(B_UP);
    check("speed_sat_hi", 32'(SPEED), 32'd3);
    repeat (5) press(B_DOWN);
    check("speed_sat_lo", 32'(SPEED), 32'd0);
    tick_gap(n);
    tick_gap(n);
    check("period_back_s0", 32'(n), 32'd16);

    // Bouncing ONOFF: 1,0,1,0 then held.
    r0 = RUN;
    raw = B_ONOFF; cyc(); raw = '0; cyc(); raw = B_ONOFF; cyc(); raw = '0; cyc();
    raw = B_ONOFF;
    toggles = 0; first = -1;
    for (int k = 1; k <= 24; k++) begin
      cyc();
      if (RUN != r0) begin
        toggles++;
        if (first < 0) first = k;
        r0 = RUN;
      end
      if (k == 10) raw = '0;
    end
    check("bounce_toggles", 32'(toggles), 32'd1);
    check("bounce_latency", 32'(first), 32'd8);

    // Manual steps.
    if (RUN) press(B_ONOFF);
    press_count(B_ADD, 8, na, ns, nc, nt);
    check("add_stopped", 32'(na), 32'd1);
    check("add_stopped_nosub", 32'(ns), 32'd0);
    press_count(B_SUB, 8, na, ns, nc, nt);
    check("sub_stopped", 32'(ns), 32'd1);
    press_count(B_ADD | B_SUB, 8, na, ns, nc, nt);
    check("add_sub_both", 32'(na + ns), 32'd0);
    press(B_ONOFF);
    press_count(B_ADD, 8, na, ns, nc, nt);
    check("add_running", 32'(na), 32'd0);

    // ONOFF and CLEAR together while running.
    press_count(B_ONOFF | B_CLEAR, 8, na, ns, nc, nt);
    check("clr_count", 32'(nc), 32'd1);
    check("run_after_clr", 32'(RUN), 32'd0);
    nt = 0;
    repeat (40) begin cyc(); nt += int'(TICK); end
    check("no_tick_after_clr", 32'(nt), 32'd0);

    // REVERSE while running keeps the tick phase.
    press(B_ONOFF);
    tick_gap(n);
    dir0 = int'(DIR);
    raw = B_REV;
    t1 = -1; t2 = -1; dflip = -1;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      if (int'(DIR) != dir0 && dflip < 0) dflip = k;
      if (TICK) begin
        if (t1 < 0) t1 = k;
        else if (t2 < 0) t2 = k;
      end
      if (k == 10) raw = '0;
    end
    check("dir_flip", 32'(dflip), 32'd8);
    check("rev_tick1", 32'(t1), 32'd16);
    check("rev_tick2", 32'(t2), 32'd32);

    // Random buttons with occasional reset, checked every cycle by the model.
    for (int i = 0; i < 7; i++) rem[i] = $urandom_range(1, 12);
    for (int c = 0; c < 3000; c++) begin
      cyc();
      RESET = ($urandom_range(0, 599) == 0);
      for (int i = 0; i < 7; i++) begin
        if (rem[i] == 0) begin
          raw[i] = ~raw[i];
          rem[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(DB + 2, DB + 12)
                                               : $urandom_range(1, 3);
        end else begin
          rem[i]--;
        end
      end
    end
    raw = '0;
    RESET = 1'b0;
    repeat (4) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
